clock_ui_io: RTL and testbench



---
 rtl/clock_ui_io_if.sv | 37 +++
 rtl/clock_ui_io.sv | 150 +++++++++++++++
 tb/tb_clock_ui_io.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/clock_ui_io_if.sv
`default_nettype none
// ============================================================================
// Module      : clock_ui_io_if
// Description : Pin/control-side bundle for the clock user-interface I/O block
// Revision    : 1.0 - initial release
// ============================================================================
interface clock_ui_io_if;
    logic        set_button_raw;
    logic        beep_button_raw;
    logic        add_button_raw;
    logic        square_wave;
    logic        beep_match;
    logic        flash_hour;
    logic        flash_minute;
    logic        flash_second;
    logic [47:0] seg_data_in;
    logic        set_pulse;
    logic        add_pulse;
    logic        beep_enabled;
    logic        beep_port;
    logic [47:0] seg_data_out;

    modport master (
        output set_button_raw, beep_button_raw, add_button_raw,
        output square_wave, beep_match,
        output flash_hour, flash_minute, flash_second, seg_data_in,
        input  set_pulse, add_pulse, beep_enabled, beep_port, seg_data_out
    );

    modport slave (
        input  set_button_raw, beep_button_raw, add_button_raw,
        input  square_wave, beep_match,
        input  flash_hour, flash_minute, flash_second, seg_data_in,
        output set_pulse, add_pulse, beep_enabled, beep_port, seg_data_out
    );
endinterface
`default_nettype wire

// File: rtl/clock_ui_io.sv
`default_nettype none
// ============================================================================
// Module      : clock_ui_io
// Description : Button debounce, alarm enable/buzzer burst and digit blinking
// Revision    : 1.0 - initial release
// ============================================================================
module clock_ui_io #(
    parameter int         DEBOUNCE_CYCLES = 500_000,
    parameter int         BEEP_EDGES      = 60,
    parameter logic [7:0] BLANK_CODE      = 8'hFF
) (
    input wire           clk,
    input wire           rst,
    clock_ui_io_if.slave ui
);

    localparam int c_DB_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_DB_CNT_W-1:0] c_DB_LAST = c_DB_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int c_EDGE_W = $clog2(BEEP_EDGES + 1);
    localparam logic [c_EDGE_W-1:0] c_EDGE_LAST = c_EDGE_W'(BEEP_EDGES - 1);
    localparam int c_NUM_BTN  = 3;
    localparam int c_BTN_SET  = 0;
    localparam int c_BTN_BEEP = 1;
    localparam int c_BTN_ADD  = 2;
    localparam int c_NUM_DIG  = 6;

    logic [c_NUM_BTN-1:0] w_btn_raw;
    logic [c_NUM_BTN-1:0] w_btn_pulse;

    assign w_btn_raw = {ui.add_button_raw, ui.beep_button_raw, ui.set_button_raw};

    // Buttons are active-low, so an accepted release is a 0->1 move of the stable level.
    generate
        for (genvar g = 0; g < c_NUM_BTN; g++) begin : g_debounce
            logic                  r_sync_meta;
            logic                  r_sync;
            logic                  r_stable;
            logic                  r_stable_d;
            logic                  r_pulse;
            logic [c_DB_CNT_W-1:0] r_cnt;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync_meta <= 1'b1;
                    r_sync      <= 1'b1;
                    r_stable    <= 1'b1;
                    r_stable_d  <= 1'b1;
                    r_pulse     <= 1'b0;
                    r_cnt       <= '0;
                end else begin
                    r_sync_meta <= w_btn_raw[g];
                    r_sync      <= r_sync_meta;
                    r_stable_d  <= r_stable;
                    r_pulse     <= r_stable & ~r_stable_d;
                    if (r_sync != r_stable) begin
                        if (r_cnt == c_DB_LAST) begin
                            r_stable <= r_sync;
                            r_cnt    <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                end
            end

            assign w_btn_pulse[g] = r_pulse;
        end
    endgenerate

    logic                r_beep_enabled;
    logic                r_sq_d;
    logic                r_match_d;
    logic                r_active;
    logic [c_EDGE_W-1:0] r_edge_cnt;
    logic                r_beep_port;
    logic                w_sq_rise;
    logic                w_match_rise;

    assign w_sq_rise    = ui.square_wave & ~r_sq_d;
    assign w_match_rise = ui.beep_match & ~r_match_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beep_enabled <= 1'b0;
            r_sq_d         <= 1'b0;
            r_match_d      <= 1'b0;
            r_active       <= 1'b0;
            r_edge_cnt     <= '0;
            r_beep_port    <= 1'b0;
        end else begin
            r_sq_d      <= ui.square_wave;
            r_match_d   <= ui.beep_match;
            r_beep_port <= r_active & ui.square_wave;
            if (w_btn_pulse[c_BTN_BEEP]) begin
                r_beep_enabled <= ~r_beep_enabled;
            end
            // Disable wins over a fresh match edge; a new edge mid-burst restarts the count.
            if (!r_beep_enabled) begin
                r_active <= 1'b0;
            end else if (w_match_rise) begin
                r_active   <= 1'b1;
                r_edge_cnt <= '0;
            end else if (r_active && w_sq_rise) begin
                if (r_edge_cnt == c_EDGE_LAST) begin
                    r_active   <= 1'b0;
                    r_edge_cnt <= '0;
                end else begin
                    r_edge_cnt <= r_edge_cnt + 1'b1;
                end
            end
        end
    end

    logic [47:0] w_seg_next;
    logic [47:0] r_seg;

    // Digit 0 sits in the top byte; pairs (0,1),(2,3),(4,5) map to hour/minute/second.
    generate
        for (genvar d = 0; d < c_NUM_DIG; d++) begin : g_flash
            logic w_grp_flash;
            if (d < 2) begin : g_hour
                assign w_grp_flash = ui.flash_hour;
            end else if (d < 4) begin : g_minute
                assign w_grp_flash = ui.flash_minute;
            end else begin : g_second
                assign w_grp_flash = ui.flash_second;
            end
            assign w_seg_next[47-8*d -: 8] = (w_grp_flash && !ui.square_wave)
                                           ? BLANK_CODE : ui.seg_data_in[47-8*d -: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg <= {c_NUM_DIG{BLANK_CODE}};
        end else begin
            r_seg <= w_seg_next;
        end
    end

    assign ui.set_pulse    = w_btn_pulse[c_BTN_SET];
    assign ui.add_pulse    = w_btn_pulse[c_BTN_ADD];
    assign ui.beep_enabled = r_beep_enabled;
    assign ui.beep_port    = r_beep_port;
    assign ui.seg_data_out = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_clock_ui_io.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_ui_io
// Description : Directed self-checking bench for clock_ui_io
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_ui_io;

    logic clk = 1'b0;
    logic rst = 1'b1;

    clock_ui_io_if ui_if ();

    clock_ui_io #(
        .DEBOUNCE_CYCLES (8),
        .BEEP_EDGES      (4),
        .BLANK_CODE      (8'hFF)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .ui  (ui_if)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    int   sq_ph    = 0;
    bit   sq_en    = 1'b0;
    int   cnt_set  = 0;
    int   cnt_add  = 0;
    int   cnt_hi   = 0;
    int   cnt_rise = 0;
    logic prev_port = 1'b0;

    task automatic check_value(input string tag, input logic [47:0] actual,
                               input logic [47:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic clear_counts();
        cnt_set  = 0;
        cnt_add  = 0;
        cnt_hi   = 0;
        cnt_rise = 0;
    endtask

    // Advance one clock, sample registered outputs, then step the square wave.
    task automatic tick();
        @(posedge clk);
        #1;
        if (ui_if.set_pulse) cnt_set++;
        if (ui_if.add_pulse) cnt_add++;
        if (ui_if.beep_port) cnt_hi++;
        if (ui_if.beep_port && !prev_port) cnt_rise++;
        prev_port = ui_if.beep_port;
        if (sq_en) begin
            sq_ph = (sq_ph + 1) % 10;
            ui_if.square_wave = (sq_ph >= 5);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press_release_beep();
        ui_if.beep_button_raw = 1'b0;
        ticks(14);
        ui_if.beep_button_raw = 1'b1;
        ticks(14);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int  first;
        bit  found;

        ui_if.set_button_raw  = 1'b1;
        ui_if.beep_button_raw = 1'b1;
        ui_if.add_button_raw  = 1'b1;
        ui_if.square_wave     = 1'b0;
        ui_if.beep_match      = 1'b0;
        ui_if.flash_hour      = 1'b0;
        ui_if.flash_minute    = 1'b0;
        ui_if.flash_second    = 1'b0;
        ui_if.seg_data_in     = 48'h0102_0304_0506;

        ticks(3);
        check_value("rst_set_pulse", 48'(ui_if.set_pulse), 48'd0);
        check_value("rst_add_pulse", 48'(ui_if.add_pulse), 48'd0);
        check_value("rst_beep_en", 48'(ui_if.beep_enabled), 48'd0);
        check_value("rst_beep_port", 48'(ui_if.beep_port), 48'd0);
        check_value("rst_seg", ui_if.seg_data_out, 48'hFFFF_FFFF_FFFF);

        rst = 1'b0;
        clear_counts();
        ticks(10);
        check_value("post_rst_set", 48'(cnt_set), 48'd0);
        check_value("post_rst_add", 48'(cnt_add), 48'd0);

        // Set button: long press, then release -> one pulse 11 cycles later.
        ui_if.set_button_raw = 1'b0;
        clear_counts();
        ticks(20);
        check_value("set_press_nopulse", 48'(cnt_set), 48'd0);
        ui_if.set_button_raw = 1'b1;
        clear_counts();
        first = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (ui_if.set_pulse && first < 0) first = k;
        end
        check_value("set_latency", 48'(first), 48'd11);
        check_value("set_count", 48'(cnt_set), 48'd1);
        check_value("set_add_quiet", 48'(cnt_add), 48'd0);

        // Add button bounces shorter than the debounce window.
        clear_counts();
        for (int b = 0; b < 5; b++) begin
            ui_if.add_button_raw = 1'b0;
            ticks(3);
            ui_if.add_button_raw = 1'b1;
            ticks(3);
        end
        ticks(15);
        check_value("bounce_add", 48'(cnt_add), 48'd0);
        check_value("bounce_set", 48'(cnt_set), 48'd0);

        press_release_beep();
        check_value("beep_toggle1", 48'(ui_if.beep_enabled), 48'd1);
        press_release_beep();
        check_value("beep_toggle2", 48'(ui_if.beep_enabled), 48'd0);
        press_release_beep();
        check_value("beep_toggle3", 48'(ui_if.beep_enabled), 48'd1);

        // Burst: match rises with square low; edges at n=5,15,25,35 -> 5+5+5+1 high cycles.
        ticks(3);
        sq_ph = 0;
        sq_en = 1'b1;
        ui_if.beep_match = 1'b1;
        clear_counts();
        ticks(100);
        check_value("burst_hi_cycles", 48'(cnt_hi), 48'd16);
        check_value("burst_rises", 48'(cnt_rise), 48'd4);
        ui_if.beep_match = 1'b0;
        ticks(2);

        // Disable mid-burst through the beep button.
        ui_if.beep_button_raw = 1'b0;
        ticks(14);
        ui_if.beep_match = 1'b1;
        clear_counts();
        ticks(8);
        ui_if.beep_button_raw = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (!ui_if.beep_enabled) begin
                found = 1'b1;
                break;
            end
        end
        check_value("disable_seen", 48'(found), 48'd1);
        check_value("disable_burst_ran", 48'(cnt_hi > 0), 48'd1);
        ticks(2);
        check_value("disable_port0", 48'(ui_if.beep_port), 48'd0);
        clear_counts();
        ticks(20);
        check_value("disable_stays0", 48'(cnt_hi), 48'd0);
        ui_if.beep_match = 1'b0;

        // Match edge with alarm disabled.
        ticks(3);
        ui_if.beep_match = 1'b1;
        clear_counts();
        ticks(100);
        check_value("disabled_burst", 48'(cnt_hi), 48'd0);
        ui_if.beep_match = 1'b0;

        // Reset in the middle of a burst and of a set-button debounce.
        press_release_beep();
        check_value("reen_beep", 48'(ui_if.beep_enabled), 48'd1);
        ticks(2);
        clear_counts();
        ui_if.beep_match = 1'b1;
        ticks(12);
        check_value("rst_burst_ran", 48'(cnt_hi > 0), 48'd1);
        ui_if.set_button_raw = 1'b0;
        ticks(4);
        rst = 1'b1;
        tick();
        check_value("rst_mid_port", 48'(ui_if.beep_port), 48'd0);
        ui_if.set_button_raw = 1'b1;
        ticks(2);
        rst = 1'b0;
        clear_counts();
        ticks(50);
        check_value("rst_no_restart", 48'(cnt_hi), 48'd0);
        check_value("rst_no_set", 48'(cnt_set), 48'd0);
        check_value("rst_beep_off", 48'(ui_if.beep_enabled), 48'd0);
        ui_if.beep_match = 1'b0;

        // Flash blanking.
        sq_en = 1'b0;
        ui_if.square_wave  = 1'b0;
        ui_if.seg_data_in  = 48'h0102_0304_0506;
        ui_if.flash_minute = 1'b1;
        tick();
        check_value("flash_min_low", ui_if.seg_data_out, 48'h0102_FFFF_0506);
        ui_if.square_wave = 1'b1;
        tick();
        check_value("flash_min_high", ui_if.seg_data_out, 48'h0102_0304_0506);
        ui_if.flash_minute = 1'b0;
        ui_if.square_wave  = 1'b0;
        tick();
        check_value("flash_none", ui_if.seg_data_out, 48'h0102_0304_0506);
        ui_if.flash_hour   = 1'b1;
        ui_if.flash_second = 1'b1;
        tick();
        check_value("flash_hr_sec", ui_if.seg_data_out, 48'hFFFF_0304_FFFF);
        ui_if.flash_hour   = 1'b0;
        ui_if.flash_second = 1'b0;
        ui_if.seg_data_in  = 48'hA1B2_C3D4_E5F6;
        tick();
        check_value("flash_passthru", ui_if.seg_data_out, 48'hA1B2_C3D4_E5F6);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
